// File: rtl/riscv_if_if.sv
// Fetch-stage bundle: instruction-memory request/response channels plus the
// decode-side valid/ready handshake. The fetch stage is the master.
interface riscv_if_if #(
    parameter int XLEN = 32
);
    logic            imem_req_valid;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_req_ready;
    logic            imem_resp_valid;
    logic [XLEN-1:0] imem_resp_data;
    logic [XLEN-1:0] instruction;
    logic [XLEN-1:0] pc;
    logic            valid;
    logic            id_ready;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
        output instruction, pc, valid,
        input  id_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
        input  instruction, pc, valid,
        output id_ready
    );
endinterface

// File: rtl/riscv_if.sv
// RISC-V instruction fetch: owns the fetch PC, keeps at most DEPTH words in flight
// or buffered, tags in-order responses with their PC and hands them to decode.
module riscv_if #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    riscv_if_if.master      bus,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            misaligned
);
    localparam int          AW    = $clog2(DEPTH);
    localparam int          CW    = $clog2(DEPTH + 1);
    localparam logic [CW:0] LIMIT = (CW + 1)'(DEPTH);

    typedef enum logic {RUN, HALT} state_t;

    state_t          state;
    logic [XLEN-1:0] fetch_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   count;
    logic [CW-1:0]   drop;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   tag_wr_ptr;
    logic [AW-1:0]   tag_rd_ptr;
    logic [XLEN-1:0] fifo_instr [DEPTH];
    logic [XLEN-1:0] fifo_pc    [DEPTH];
    logic [XLEN-1:0] tag_pc     [DEPTH];
    logic [CW:0]     budget;
    logic            req_valid;
    logic            accept;
    logic            push;
    logic            pop;
    logic            head_valid;
    logic            aligned;

    // In-flight plus buffered words never exceed DEPTH, so a pushed response always fits.
    always_comb begin
        budget     = {1'b0, outstanding} + {1'b0, count};
        req_valid  = !rst && (state == RUN) && !redirect && (budget < LIMIT);
        accept     = req_valid && bus.imem_req_ready;
        head_valid = (count != '0);
        push       = (state == RUN) && !redirect && bus.imem_resp_valid && (drop == '0);
        pop        = head_valid && bus.id_ready;
        aligned    = (redirect_pc[1:0] == 2'b00);
    end

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = fetch_pc;
    assign bus.valid          = head_valid;
    assign bus.instruction    = head_valid ? fifo_instr[rd_ptr] : '0;
    assign bus.pc             = head_valid ? fifo_pc[rd_ptr] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            count       <= '0;
            drop        <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            tag_wr_ptr  <= '0;
            tag_rd_ptr  <= '0;
            misaligned  <= 1'b0;
        end else begin
            case ({accept, bus.imem_resp_valid})
                2'b10:   outstanding <= outstanding + CW'(1);
                2'b01:   outstanding <= outstanding - CW'(1);
                default: outstanding <= outstanding;
            endcase

            if (state == RUN) begin
                if (redirect) begin
                    // Everything still in flight after this cycle belongs to the old path.
                    count      <= '0;
                    wr_ptr     <= '0;
                    rd_ptr     <= '0;
                    tag_wr_ptr <= '0;
                    tag_rd_ptr <= '0;
                    drop       <= outstanding - CW'(bus.imem_resp_valid);
                    if (aligned) begin
                        fetch_pc <= redirect_pc;
                    end else begin
                        state      <= HALT;
                        misaligned <= 1'b1;
                    end
                end else begin
                    if (accept) begin
                        fetch_pc   <= fetch_pc + XLEN'(4);
                        tag_wr_ptr <= tag_wr_ptr + AW'(1);
                    end
                    if (bus.imem_resp_valid) begin
                        if (drop != '0) begin
                            drop <= drop - CW'(1);
                        end else begin
                            tag_rd_ptr <= tag_rd_ptr + AW'(1);
                        end
                    end
                    if (push) begin
                        wr_ptr <= wr_ptr + AW'(1);
                    end
                    if (pop) begin
                        rd_ptr <= rd_ptr + AW'(1);
                    end
                    if (push && !pop) begin
                        count <= count + CW'(1);
                    end else if (!push && pop) begin
                        count <= count - CW'(1);
                    end
                end
            end else begin
                if (bus.imem_resp_valid && (drop != '0)) begin
                    drop <= drop - CW'(1);
                end
            end
        end
    end

    // Tag and data storage need no reset; occupancy is tracked by the pointers above.
    always_ff @(posedge clk) begin
        if (accept) begin
            tag_pc[tag_wr_ptr] <= fetch_pc;
        end
        if (push) begin
            fifo_instr[wr_ptr] <= bus.imem_resp_data;
            fifo_pc[wr_ptr]    <= tag_pc[tag_rd_ptr];
        end
    end
endmodule

// File: tb/tb_riscv_if.sv
// Self-checking bench for riscv_if: in-order memory model with programmable latency,
// a per-cycle vector table for streaming/backpressure and directed corner sequences.
module tb_riscv_if;
    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        misaligned;

    riscv_if_if #(.XLEN(32)) bus ();

    riscv_if #(.XLEN(32), .RESET_PC(32'h0), .DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .misaligned  (misaligned)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    typedef struct {
        logic        idr;
        logic        rv;
        logic [31:0] addr;
        logic        v;
        logic [31:0] pc;
    } vec_t;

    pend_t pend[$];
    vec_t  vecs[21];
    int    tests = 0;
    int    fails = 0;
    int    cyc = 0;
    int    mem_lat = 1;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return 32'h1000 + (a >> 2);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic idr, input logic rdy, input logic redir, input logic [31:0] rpc);
        bus.id_ready       = idr;
        bus.imem_req_ready = rdy;
        redirect           = redir;
        redirect_pc        = rpc;
        #1;
    endtask

    // Memory model: record the acceptance seen before the edge, then present at most
    // one in-order response per cycle once its latency has elapsed.
    task automatic clockCycle();
        logic        acc;
        logic [31:0] a;
        acc = bus.imem_req_valid && bus.imem_req_ready;
        a   = bus.imem_req_addr;
        @(posedge clk);
        #1;
        cyc++;
        if (acc) pend.push_back('{a, cyc - 1 + mem_lat});
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            bus.imem_resp_valid = 1'b1;
            bus.imem_resp_data  = memword(pend[0].addr);
            void'(pend.pop_front());
        end else begin
            bus.imem_resp_valid = 1'b0;
            bus.imem_resp_data  = 32'h0;
        end
    endtask

    task automatic doReset(input int lat);
        rst                 = 1'b1;
        redirect            = 1'b0;
        redirect_pc         = 32'h0;
        bus.id_ready        = 1'b0;
        bus.imem_req_ready  = 1'b1;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = 32'h0;
        pend.delete();
        mem_lat = lat;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        // Streaming with a 10-cycle decode stall starting at cycle 4, 1-cycle memory.
        vecs[0]  = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
        vecs[1]  = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
        vecs[2]  = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
        vecs[3]  = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h04};
        vecs[4]  = '{1'b0, 1'b1, 32'h10, 1'b1, 32'h08};
        vecs[5]  = '{1'b0, 1'b1, 32'h14, 1'b1, 32'h08};
        vecs[6]  = '{1'b0, 1'b0, 32'h18, 1'b1, 32'h08};
        for (int i = 7; i <= 13; i++) vecs[i] = '{1'b0, 1'b0, 32'h18, 1'b1, 32'h08};
        vecs[14] = '{1'b1, 1'b0, 32'h18, 1'b1, 32'h08};
        vecs[15] = '{1'b1, 1'b1, 32'h18, 1'b1, 32'h0C};
        vecs[16] = '{1'b1, 1'b1, 32'h1C, 1'b1, 32'h10};
        vecs[17] = '{1'b1, 1'b1, 32'h20, 1'b1, 32'h14};
        vecs[18] = '{1'b1, 1'b1, 32'h24, 1'b1, 32'h18};
        vecs[19] = '{1'b1, 1'b1, 32'h28, 1'b1, 32'h1C};
        vecs[20] = '{1'b1, 1'b1, 32'h2C, 1'b1, 32'h20};

        rst                 = 1'b1;
        redirect            = 1'b0;
        redirect_pc         = 32'h0;
        bus.id_ready        = 1'b0;
        bus.imem_req_ready  = 1'b1;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = 32'h0;
        #2;
        checkOutput("reset_req_valid", 32'(bus.imem_req_valid), 32'h0);
        checkOutput("reset_req_addr", bus.imem_req_addr, 32'h0);
        checkOutput("reset_valid", 32'(bus.valid), 32'h0);
        checkOutput("reset_instruction", bus.instruction, 32'h0);
        checkOutput("reset_pc", bus.pc, 32'h0);
        checkOutput("reset_misaligned", 32'(misaligned), 32'h0);

        doReset(1);
        for (int i = 0; i < 21; i++) begin
            applyStimulus(vecs[i].idr, 1'b1, 1'b0, 32'h0);
            checkOutput("tbl_req_valid", 32'(bus.imem_req_valid), 32'(vecs[i].rv));
            checkOutput("tbl_req_addr", bus.imem_req_addr, vecs[i].addr);
            checkOutput("tbl_valid", 32'(bus.valid), 32'(vecs[i].v));
            if (vecs[i].v) begin
                checkOutput("tbl_pc", bus.pc, vecs[i].pc);
                checkOutput("tbl_instruction", bus.instruction, memword(vecs[i].pc));
            end
            clockCycle();
        end

        // Memory refuses the 0x8 request for three cycles.
        doReset(1);
        for (int c = 0; c < 8; c++) begin
            applyStimulus(1'b1, (c >= 2 && c <= 4) ? 1'b0 : 1'b1, 1'b0, 32'h0);
            if (c >= 2 && c <= 5) begin
                checkOutput("stall_req_valid", 32'(bus.imem_req_valid), 32'h1);
                checkOutput("stall_req_addr", bus.imem_req_addr, 32'h8);
            end
            if (c == 6) checkOutput("stall_next_addr", bus.imem_req_addr, 32'hC);
            if (c == 3) checkOutput("stall_pc4", bus.pc, 32'h4);
            if (c >= 4 && c <= 6) checkOutput("stall_bubble", 32'(bus.valid), 32'h0);
            if (c == 7) begin
                checkOutput("stall_valid8", 32'(bus.valid), 32'h1);
                checkOutput("stall_pc8", bus.pc, 32'h8);
                checkOutput("stall_instr8", bus.instruction, 32'h1002);
            end
            clockCycle();
        end

        // 3-cycle memory: redirect while 0x10 and 0x14 are in flight.
        doReset(3);
        for (int c = 0; c < 10; c++) begin
            applyStimulus(1'b1, 1'b1, (c == 0) || (c == 3), (c == 0) ? 32'h10 : 32'h100);
            if (c == 0 || c == 3) checkOutput("redir_blocks_req", 32'(bus.imem_req_valid), 32'h0);
            if (c == 1) checkOutput("redir_addr10", bus.imem_req_addr, 32'h10);
            if (c == 2) checkOutput("redir_addr14", bus.imem_req_addr, 32'h14);
            if (c == 4) begin
                checkOutput("redir_new_req_valid", 32'(bus.imem_req_valid), 32'h1);
                checkOutput("redir_new_addr", bus.imem_req_addr, 32'h100);
            end
            if (c >= 4 && c <= 7) checkOutput("redir_dropped", 32'(bus.valid), 32'h0);
            if (c == 8) begin
                checkOutput("redir_valid", 32'(bus.valid), 32'h1);
                checkOutput("redir_pc100", bus.pc, 32'h100);
                checkOutput("redir_instr100", bus.instruction, 32'h1040);
            end
            if (c == 9) begin
                checkOutput("redir_pc104", bus.pc, 32'h104);
                checkOutput("redir_instr104", bus.instruction, 32'h1041);
            end
            clockCycle();
        end

        // Mid-stream redirect to the top of the address space with 1-cycle memory.
        doReset(1);
        for (int c = 0; c < 9; c++) begin
            applyStimulus(1'b1, 1'b1, (c == 3), 32'hFFFF_FFFC);
            if (c == 3) checkOutput("wrap_blocks_req", 32'(bus.imem_req_valid), 32'h0);
            if (c == 4) checkOutput("wrap_addr_top", bus.imem_req_addr, 32'hFFFF_FFFC);
            if (c == 5) checkOutput("wrap_addr_zero", bus.imem_req_addr, 32'h0);
            if (c == 4 || c == 5) checkOutput("wrap_flushed", 32'(bus.valid), 32'h0);
            if (c == 6) begin
                checkOutput("wrap_pc_top", bus.pc, 32'hFFFF_FFFC);
                checkOutput("wrap_instr_top", bus.instruction, 32'h4000_0FFF);
            end
            if (c == 7) begin
                checkOutput("wrap_pc0", bus.pc, 32'h0);
                checkOutput("wrap_instr0", bus.instruction, 32'h1000);
            end
            if (c == 8) begin
                checkOutput("wrap_valid4", 32'(bus.valid), 32'h1);
                checkOutput("wrap_pc4", bus.pc, 32'h4);
            end
            clockCycle();
        end

        // Misaligned redirect halts fetch until reset; later redirects are ignored.
        doReset(1);
        for (int c = 0; c < 10; c++) begin
            applyStimulus(1'b0, 1'b1, (c == 3) || (c == 6), (c == 3) ? 32'h102 : 32'h200);
            if (c == 3) checkOutput("mis_before", 32'(misaligned), 32'h0);
            if (c >= 4) begin
                checkOutput("mis_flag", 32'(misaligned), 32'h1);
                checkOutput("mis_valid", 32'(bus.valid), 32'h0);
                checkOutput("mis_req_valid", 32'(bus.imem_req_valid), 32'h0);
            end
            clockCycle();
        end
        rst = 1'b1;
        #1;
        checkOutput("mis_rst_clears", 32'(misaligned), 32'h0);
        doReset(1);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("mis_restart_req", 32'(bus.imem_req_valid), 32'h1);
        checkOutput("mis_restart_addr", bus.imem_req_addr, 32'h0);

        // Asynchronous reset with buffered words and requests still in flight.
        doReset(3);
        for (int c = 0; c < 5; c++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
            clockCycle();
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("arst_pre_valid", 32'(bus.valid), 32'h1);
        checkOutput("arst_pre_pc", bus.pc, 32'h0);
        rst = 1'b1;
        #1;
        checkOutput("arst_req_valid", 32'(bus.imem_req_valid), 32'h0);
        checkOutput("arst_req_addr", bus.imem_req_addr, 32'h0);
        checkOutput("arst_valid", 32'(bus.valid), 32'h0);
        checkOutput("arst_instruction", bus.instruction, 32'h0);
        checkOutput("arst_pc", bus.pc, 32'h0);
        doReset(1);
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
            if (c == 0) checkOutput("arst_restart_addr", bus.imem_req_addr, 32'h0);
            if (c == 2) begin
                checkOutput("arst_restart_valid", 32'(bus.valid), 32'h1);
                checkOutput("arst_restart_pc", bus.pc, 32'h0);
                checkOutput("arst_restart_instr", bus.instruction, 32'h1000);
            end
            clockCycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
